// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//
// Converts parallel words into a serial bit stream for a downstream sequence
// detector. A one-word holding buffer lets the next word be queued while the
// current one is shifting, so back-to-back words produce a gapless stream.
//
// Parameters
//   WIDTH      word length in bits, legal range 2..32
//   MSB_FIRST  1: most significant bit goes out first, 0: least significant
//
// Ports
//   clock          single clock, all state changes on its rising edge
//   reset          asynchronous, active-low; clears all state immediately
//   data_in        parallel word to serialize
//   load_valid     data_in is offered this cycle
//   load_ready     block accepts data_in this cycle
//   serial_enable  low pauses shifting (shift register, counter, FSM hold)
//   serial_out     serial bit stream
//   serial_valid   serial_out carries a frame bit this cycle
//   frame_done     one-cycle pulse after the last bit of a word is consumed
// -----------------------------------------------------------------------------
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             serial_enable,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_done
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] buf_data;
    logic             buf_full;
    logic             head_bit;
    logic             accept;
    logic             last_edge;
    logic             to_buffer;

    // Handshake and edge qualifiers shared by the FSM and the datapath.
    assign accept    = load_valid && load_ready;
    assign last_edge = (state == SHIFT) && serial_enable && (bit_cnt == LAST_CNT);
    // A word accepted while shifting is queued, unless this is the last-bit
    // edge: then it bypasses straight into the shift register.
    assign to_buffer = accept && (state == SHIFT) && !last_edge;

    // Shift direction and the bit currently presented are fixed by MSB_FIRST.
    always_comb begin
        if (MSB_FIRST != 0) begin
            shifted  = {shift_reg[WIDTH-2:0], 1'b0};
            head_bit = shift_reg[WIDTH-1];
        end else begin
            shifted  = {1'b0, shift_reg[WIDTH-1:1]};
            head_bit = shift_reg[0];
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                // Stay in SHIFT if another word is ready (buffered or bypass).
                if (last_edge && !buf_full && !accept) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        load_ready   = (state == IDLE) || !buf_full;
        serial_valid = (state == SHIFT) && serial_enable;
        // Forced low in IDLE; while paused the shift register holds, so the
        // presented bit holds too.
        serial_out   = (state == SHIFT) ? head_bit : 1'b0;
    end

    // -------------------------------------------------------------------------
    // Datapath: shift register, bit counter, buffer flag, frame pulse
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            buf_full   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= last_edge;

            if (state == IDLE) begin
                if (accept) begin
                    shift_reg <= data_in;
                    bit_cnt   <= '0;
                end
            end else if (serial_enable) begin
                if (bit_cnt == LAST_CNT) begin
                    bit_cnt <= '0;
                    if (buf_full) begin
                        shift_reg <= buf_data;
                    end else if (accept) begin
                        shift_reg <= data_in;
                    end else begin
                        // Final shift leaves the register all zeros.
                        shift_reg <= shifted;
                    end
                end else begin
                    shift_reg <= shifted;
                    bit_cnt   <= bit_cnt + CW'(1);
                end
            end

            // load_ready is low while full, so a buffered transfer and a new
            // buffer load can never coincide.
            if (last_edge && buf_full) begin
                buf_full <= 1'b0;
            end else if (to_buffer) begin
                buf_full <= 1'b1;
            end
        end
    end

    // NOTE: the buffer payload has no reset; buf_full qualifies it, so its
    // contents are never observed before being written.
    always_ff @(posedge clock) begin
        if (to_buffer) begin
            buf_data <= data_in;
        end
    end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the word length in bits; legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning bit order: 1 sends the MSB first, 0 sends the LSB first.
REQ-003 SHALL have port clock, input, width 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, width 1; it is asynchronous and active-low, and reset=0 clears all state immediately.
REQ-005 SHALL have port data_in, input, width WIDTH, the parallel word to serialize.
REQ-006 SHALL have port load_valid, input, width 1; high means data_in is offered.
REQ-007 SHALL have port load_ready, output, width 1; high means the block accepts data_in this cycle.
REQ-008 SHALL have port serial_enable, input, width 1; low pauses shifting.
REQ-009 SHALL have port serial_out, output, width 1, the serial bit stream for the downstream sequence detector's sequence_in.
REQ-010 SHALL have port serial_valid, output, width 1; high means serial_out carries a frame bit this cycle.
REQ-011 SHALL have port frame_done, output, width 1, a one-cycle pulse when the last bit of a word has been consumed.

Function
REQ-012 SHALL contain a WIDTH-bit shift register, a bit counter of ceil(log2(WIDTH)) bits, a one-word holding buffer with a full flag, and a 2-state FSM (IDLE, SHIFT).
REQ-013 SHALL accept a word only on a rising edge where load_valid=1 and load_ready=1; load_ready SHALL be (state==IDLE) or (buffer not full).
REQ-014 In IDLE, an accepted word SHALL load directly into the shift register; at the same edge the counter is cleared and the FSM enters SHIFT; the first bit appears on serial_out after that edge (latency 1 edge).
REQ-015 In SHIFT with the buffer empty and not on the last bit, an accepted word SHALL go to the holding buffer and set the full flag.
REQ-016 In SHIFT with serial_enable=1, each edge SHALL shift one bit and increment the counter; serial_out is the shift-register MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0).
REQ-017 Last-bit edge (counter==WIDTH-1, serial_enable=1) SHALL take the first applicable case:
  - buffer full: buffer moves to the shift register, full flag clears, counter clears, FSM stays in SHIFT;
  - else, word accepted this edge: it bypasses into the shift register and the FSM stays in SHIFT;
  - else: the FSM enters IDLE.
REQ-018 Back-to-back words SHALL produce a gapless stream, with serial_valid staying high across the word boundary.
REQ-019 frame_done SHALL be registered high for exactly the one cycle following each last-bit edge.
REQ-020 While serial_enable=0, the shift register, counter and FSM SHALL hold, serial_valid SHALL be 0, and serial_out SHALL hold its value; loads into the buffer remain permitted.
REQ-021 serial_valid SHALL equal (state==SHIFT) and serial_enable.
REQ-022 In IDLE, serial_out SHALL be 0 and serial_valid SHALL be 0.
REQ-023 data_in SHALL be ignored whenever load_ready=0 or load_valid=0.

Reset
REQ-024 reset=0 SHALL immediately force: FSM=IDLE, counter=0, shift register=0, buffer full flag=0, serial_out=0, serial_valid=0, frame_done=0, load_ready=1.
REQ-025 Reset asserted mid-frame SHALL discard the current word and any buffered word; no frame_done is issued for them.
REQ-026 After reset=1, the first accepting edge SHALL behave per REQ-014.

Verification
REQ-027 WIDTH=4, MSB_FIRST=1, serial_enable=1, load 4'b1011 once -> serial_out 1,0,1,1 over 4 cycles with serial_valid=1; frame_done pulses once; the block returns to IDLE with serial_out=0.
REQ-028 WIDTH=4, load 4'b1011 then 4'b0110 offered while shifting -> 8 contiguous valid bits 1,0,1,1,0,1,1,0; one frame_done per word.
REQ-029 WIDTH=4, buffer full and shifting, load_valid held high -> load_ready=0 until the buffer transfers; the third word is accepted only after that transfer.
REQ-030 WIDTH=4, MSB_FIRST=0, load 4'b1101 -> serial_out 1,0,1,1.
REQ-031 Mid-frame, serial_enable=0 for 3 cycles -> serial_valid=0 and serial_out held; on resume the remaining bits arrive in order.
REQ-032 reset pulsed low after 2 bits of 4'b1011 -> all outputs go to their reset values asynchronously; no frame_done; a subsequent load serializes correctly from bit 0.
